// File: rtl/axis_pkg.sv
// Shared constants, word type and tkeep helper for the byte-to-word unpacker.
package axis_pkg;

  localparam int AXIS_NUM_CH     = 4;
  localparam int AXIS_ID_W       = 2;
  localparam int AXIS_WORD_BYTES = 8;
  localparam int AXIS_CNT_W      = 3;
  localparam int AXIS_DATA_W     = 8 * AXIS_WORD_BYTES;

  // One output word as held in a channel's output register.
  typedef struct packed {
    logic [AXIS_DATA_W-1:0]     tdata;
    logic [AXIS_WORD_BYTES-1:0] tkeep;
    logic                       tlast;
  } axis_word_t;

  // Byte enables for a word whose last valid lane is cnt: (1 << (cnt+1)) - 1.
  function automatic logic [AXIS_WORD_BYTES-1:0] keep_from_cnt(input logic [AXIS_CNT_W-1:0] cnt);
    logic [AXIS_WORD_BYTES-1:0] keep;
    keep = '0;
    for (int i = 0; i < AXIS_WORD_BYTES; i++) begin
      keep[i] = (i <= int'(cnt));
    end
    return keep;
  endfunction

endpackage

// File: rtl/axis_byte_packer.sv
// One output channel: byte accumulator, output word register and the
// per-channel term of the shared input ready.
module axis_byte_packer
  import axis_pkg::*;
(
  input  logic                       clki,
  input  logic                       rsti,
  input  logic                       byte_accept,
  input  logic [7:0]                 byte_data,
  input  logic                       byte_last,
  output logic                       completing,
  output logic                       load_ok,
  output logic                       tvalid,
  input  logic                       tready,
  output logic [AXIS_DATA_W-1:0]     tdata,
  output logic [AXIS_WORD_BYTES-1:0] tkeep,
  output logic                       tlast
);

  logic [AXIS_CNT_W-1:0] acc_cnt_reg;
  logic [7:0]            acc_lane_reg [AXIS_WORD_BYTES];
  logic [7:0]            word_lane    [AXIS_WORD_BYTES];
  logic [AXIS_DATA_W-1:0] word_next;
  axis_word_t            out_reg;
  logic                  valid_reg;

  // A byte closes the word when it fills the last lane or ends the packet.
  assign completing = (acc_cnt_reg == AXIS_CNT_W'(AXIS_WORD_BYTES - 1)) | byte_last;

  // Non-completing bytes never touch the output register, so they are always
  // accepted; a completing byte needs the output register free or draining.
  assign load_ok = !completing | !valid_reg | tready;

  genvar gi;
  generate
    for (gi = 0; gi < AXIS_WORD_BYTES; gi++) begin : g_lane
      // Lanes below the count come from the accumulator, the current lane is
      // the incoming byte, lanes above are zero so short words are clean.
      assign word_lane[gi] = (AXIS_CNT_W'(gi) < acc_cnt_reg)  ? acc_lane_reg[gi] :
                             (AXIS_CNT_W'(gi) == acc_cnt_reg) ? byte_data        : 8'h00;
      assign word_next[8*gi +: 8] = word_lane[gi];

      // Capture an accepted byte into the lane selected by the count.
      always_ff @(posedge clki) begin
        if (rsti) begin
          acc_lane_reg[gi] <= 8'h00;
        end else if (byte_accept && (acc_cnt_reg == AXIS_CNT_W'(gi))) begin
          acc_lane_reg[gi] <= byte_data;
        end
      end
    end
  endgenerate

  // Byte counter: advance on each accepted byte, wrap to lane 0 on completion.
  always_ff @(posedge clki) begin
    if (rsti) begin
      acc_cnt_reg <= '0;
    end else if (byte_accept) begin
      if (completing) begin
        acc_cnt_reg <= '0;
      end else begin
        acc_cnt_reg <= acc_cnt_reg + AXIS_CNT_W'(1);
      end
    end
  end

  // Output register: load on completion (replacing a word draining on the same
  // edge), otherwise clear valid after a handshake; hold while stalled.
  always_ff @(posedge clki) begin
    if (rsti) begin
      valid_reg     <= 1'b0;
      out_reg.tdata <= '0;
      out_reg.tkeep <= '0;
      out_reg.tlast <= 1'b0;
    end else if (byte_accept && completing) begin
      valid_reg     <= 1'b1;
      out_reg.tdata <= word_next;
      out_reg.tkeep <= keep_from_cnt(acc_cnt_reg);
      out_reg.tlast <= byte_last;
    end else if (valid_reg && tready) begin
      valid_reg     <= 1'b0;
    end
  end

  assign tvalid = valid_reg;
  assign tdata  = out_reg.tdata;
  assign tkeep  = out_reg.tkeep;
  assign tlast  = out_reg.tlast;

endmodule

// File: rtl/axis_1to4_unpack.sv
// Steers a byte-wide AXI-Stream to NUM_CH 64-bit channels by tid and packs
// bytes little-endian into words with tkeep, independently per channel.
module axis_1to4_unpack
  import axis_pkg::*;
#(
  parameter int NUM_CH     = AXIS_NUM_CH,
  parameter int ID_W       = AXIS_ID_W,
  parameter int DATA_BYTES = AXIS_WORD_BYTES
) (
  input  logic                    clki,
  input  logic                    rsti,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  input  logic [7:0]              s_axis_tdata,
  input  logic [ID_W-1:0]         s_axis_tid,
  output logic [NUM_CH-1:0]       m_axis_tvalid,
  input  logic [NUM_CH-1:0]       m_axis_tready,
  output logic [NUM_CH-1:0]       m_axis_tlast,
  output logic [DATA_BYTES-1:0]   m_axis_tkeep [NUM_CH-1:0],
  output logic [8*DATA_BYTES-1:0] m_axis_tdata [NUM_CH-1:0]
);

  logic [NUM_CH-1:0] completing;
  logic [NUM_CH-1:0] load_ok;
  logic [NUM_CH-1:0] byte_accept;

  // The selected channel decides whether the head byte can move; reset holds
  // the input off so nothing is taken while state is being cleared.
  assign s_axis_tready = !rsti & load_ok[s_axis_tid];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign byte_accept[gi] = s_axis_tvalid & s_axis_tready & (s_axis_tid == ID_W'(gi));

      axis_byte_packer u_packer (
        .clki        (clki),
        .rsti        (rsti),
        .byte_accept (byte_accept[gi]),
        .byte_data   (s_axis_tdata),
        .byte_last   (s_axis_tlast),
        .completing  (completing[gi]),
        .load_ok     (load_ok[gi]),
        .tvalid      (m_axis_tvalid[gi]),
        .tready      (m_axis_tready[gi]),
        .tdata       (m_axis_tdata[gi]),
        .tkeep       (m_axis_tkeep[gi]),
        .tlast       (m_axis_tlast[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_axis_1to4_unpack.sv
// Self-checking bench for axis_1to4_unpack: a byte-level model pushes expected
// words per channel; a monitor pops and compares them on each output handshake.
module tb_axis_1to4_unpack;

  logic        clk = 1'b0;
  logic        rsti = 1'b1;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast = 1'b0;
  logic [7:0]  s_tdata = 8'h00;
  logic [1:0]  s_tid = 2'd0;
  logic [3:0]  m_tvalid;
  logic [3:0]  m_tready = 4'hF;
  logic [3:0]  m_tlast;
  logic [7:0]  m_tkeep [3:0];
  logic [63:0] m_tdata [3:0];

  int comps = 0;
  int errs  = 0;

  // expected {tdata, tkeep, tlast} per channel
  logic [72:0] exp_q [4][$];
  logic [63:0] mdl_word [4];
  logic [7:0]  mdl_keep [4];
  int          mdl_cnt  [4];
  int          rx_cnt   [4];

  logic        prev_stall [4];
  logic [72:0] prev_word  [4];

  always #5 clk = ~clk;

  axis_1to4_unpack dut (
    .clki          (clk),
    .rsti          (rsti),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tlast  (s_tlast),
    .s_axis_tdata  (s_tdata),
    .s_axis_tid    (s_tid),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tlast  (m_tlast),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tdata  (m_tdata)
  );

  // Output monitor: hold stability while stalled and scoreboard compare on handshake.
  always @(negedge clk) begin
    logic [72:0] got;
    logic [72:0] e;
    for (int c = 0; c < 4; c++) begin
      got = {m_tdata[c], m_tkeep[c], m_tlast[c]};
      if (rsti) begin
        prev_stall[c] = 1'b0;
      end else begin
        if (prev_stall[c]) begin
          comps++;
          if (m_tvalid[c] !== 1'b1 || got !== prev_word[c]) begin
            errs++;
            $display("FAIL hold ch%0d: got valid=%b word=%h, required valid=1 word=%h",
                     c, m_tvalid[c], got, prev_word[c]);
          end
        end
        if (m_tvalid[c] === 1'b1 && m_tready[c] === 1'b1) begin
          comps++;
          rx_cnt[c]++;
          if (exp_q[c].size() == 0) begin
            errs++;
            $display("FAIL unexpected ch%0d: got word=%h, required none", c, got);
          end else begin
            e = exp_q[c].pop_front();
            if (got !== e) begin
              errs++;
              $display("FAIL word ch%0d: got data=%h keep=%h last=%b, required data=%h keep=%h last=%b",
                       c, got[72:9], got[8:1], got[0], e[72:9], e[8:1], e[0]);
            end else begin
              $display("ch%0d word data=%h keep=%h last=%b ok", c, got[72:9], got[8:1], got[0]);
            end
          end
        end
        prev_stall[c] = (m_tvalid[c] === 1'b1) && (m_tready[c] !== 1'b1);
        prev_word[c]  = got;
      end
    end
  end

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      exp_q[c].delete();
      mdl_word[c] = '0;
      mdl_keep[c] = '0;
      mdl_cnt[c]  = 0;
    end
  endtask

  // Drive one byte, wait (bounded) for acceptance, update the model.
  task automatic send_byte(input logic [1:0] id, input logic [7:0] d, input logic last);
    int n;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tid    = id;
    s_tlast  = last;
    n = 0;
    @(negedge clk);
    while (s_tready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (s_tready !== 1'b1) begin
      comps++;
      errs++;
      $display("FAIL accept_timeout: ch%0d byte %h not accepted in 200 cycles, required accept", id, d);
    end else begin
      @(posedge clk);
      #1;
      mdl_word[id][8*mdl_cnt[id] +: 8] = d;
      mdl_keep[id][mdl_cnt[id]]        = 1'b1;
      if (mdl_cnt[id] == 7 || last) begin
        exp_q[id].push_back({mdl_word[id], mdl_keep[id], last});
        mdl_word[id] = '0;
        mdl_keep[id] = '0;
        mdl_cnt[id]  = 0;
      end else begin
        mdl_cnt[id]++;
      end
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rsti = 1'b1;
    s_tvalid = 1'b1;
    idle(3);
    comps++;
    if (s_tready !== 1'b0) begin
      errs++;
      $display("FAIL reset_tready: got %b, required 0", s_tready);
    end
    comps++;
    if (m_tvalid !== 4'b0000 || m_tlast !== 4'b0000) begin
      errs++;
      $display("FAIL reset_valid_last: got valid=%b last=%b, required 0000/0000", m_tvalid, m_tlast);
    end
    for (int c = 0; c < 4; c++) begin
      comps++;
      if (m_tdata[c] !== 64'h0 || m_tkeep[c] !== 8'h00) begin
        errs++;
        $display("FAIL reset_word ch%0d: got data=%h keep=%h, required 0/0", c, m_tdata[c], m_tkeep[c]);
      end
    end
    s_tvalid = 1'b0;
    rsti = 1'b0;
    idle(1);
    $display("reset released");
  endtask

  task automatic test_full_word();
    for (int i = 1; i <= 8; i++) send_byte(2'd2, 8'(i), i == 8);
    comps++;
    if (m_tvalid !== 4'b0100 || m_tdata[2] !== 64'h0807060504030201 ||
        m_tkeep[2] !== 8'hFF || m_tlast[2] !== 1'b1) begin
      errs++;
      $display("FAIL full_word: got valid=%b data=%h keep=%h last=%b, required 0100 0807060504030201 ff 1",
               m_tvalid, m_tdata[2], m_tkeep[2], m_tlast[2]);
    end
    idle(3);
  endtask

  task automatic test_short_packets();
    send_byte(2'd0, 8'hAA, 1'b0);
    send_byte(2'd0, 8'hBB, 1'b0);
    send_byte(2'd0, 8'hCC, 1'b1);
    comps++;
    if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== 64'h0000_0000_00CC_BBAA ||
        m_tkeep[0] !== 8'h07 || m_tlast[0] !== 1'b1) begin
      errs++;
      $display("FAIL short3: got valid=%b data=%h keep=%h last=%b, required 1 0000000000ccbbaa 07 1",
               m_tvalid[0], m_tdata[0], m_tkeep[0], m_tlast[0]);
    end
    send_byte(2'd3, 8'h5E, 1'b1);
    comps++;
    if (m_tvalid[3] !== 1'b1 || m_tdata[3] !== 64'h5E || m_tkeep[3] !== 8'h01) begin
      errs++;
      $display("FAIL short1: got valid=%b data=%h keep=%h, required 1 5e 01",
               m_tvalid[3], m_tdata[3], m_tkeep[3]);
    end
    idle(3);
  endtask

  task automatic test_interleave();
    int r0;
    int r1;
    r0 = rx_cnt[0];
    r1 = rx_cnt[1];
    for (int i = 0; i < 16; i++) begin
      send_byte(2'd0, 8'(8'h10 + i), i == 15);
      send_byte(2'd1, 8'(8'h80 + i), i == 15);
    end
    idle(4);
    comps++;
    if (rx_cnt[0] - r0 != 2 || rx_cnt[1] - r1 != 2) begin
      errs++;
      $display("FAIL interleave_count: got ch0=%0d ch1=%0d words, required 2/2", rx_cnt[0] - r0, rx_cnt[1] - r1);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] held;
    int r1;
    r1 = rx_cnt[1];
    m_tready[1] = 1'b0;
    for (int i = 0; i < 15; i++) send_byte(2'd1, 8'(8'h40 + i), 1'b0);
    // 16th byte completes the second word while the first is still stalled.
    s_tvalid = 1'b1;
    s_tdata  = 8'h4F;
    s_tid    = 2'd1;
    s_tlast  = 1'b0;
    @(negedge clk);
    comps++;
    if (s_tready !== 1'b0) begin
      errs++;
      $display("FAIL bp_tready_drop: got %b, required 0", s_tready);
    end
    held = m_tdata[1];
    idle(4);
    comps++;
    if (m_tvalid[1] !== 1'b1 || m_tdata[1] !== held || held !== 64'h4746454443424140) begin
      errs++;
      $display("FAIL bp_stable: got valid=%b data=%h, required 1 4746454443424140", m_tvalid[1], m_tdata[1]);
    end
    m_tready[1] = 1'b1;
    send_byte(2'd1, 8'h4F, 1'b0);
    for (int i = 16; i < 20; i++) send_byte(2'd1, 8'(8'h40 + i), i == 19);
    idle(4);
    comps++;
    if (rx_cnt[1] - r1 != 3) begin
      errs++;
      $display("FAIL bp_count: got %0d words, required 3", rx_cnt[1] - r1);
    end
  endtask

  task automatic test_drain_load();
    send_byte(2'd0, 8'hD1, 1'b1);
    comps++;
    if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== 64'hD1) begin
      errs++;
      $display("FAIL dl_first: got valid=%b data=%h, required 1 d1", m_tvalid[0], m_tdata[0]);
    end
    send_byte(2'd0, 8'hD2, 1'b1);
    comps++;
    if (m_tvalid[0] !== 1'b1 || m_tdata[0] !== 64'hD2) begin
      errs++;
      $display("FAIL dl_second: got valid=%b data=%h, required 1 d2", m_tvalid[0], m_tdata[0]);
    end
    idle(1);
    comps++;
    if (m_tvalid[0] !== 1'b0) begin
      errs++;
      $display("FAIL dl_clear: got valid=%b, required 0", m_tvalid[0]);
    end
    idle(2);
  endtask

  task automatic test_mid_reset();
    m_tready[2] = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(2'd2, 8'(8'h60 + i), 1'b0);
    for (int i = 0; i < 5; i++) send_byte(2'd2, 8'(8'h70 + i), 1'b0);
    rsti = 1'b1;
    idle(1);
    comps++;
    if (m_tvalid !== 4'b0000 || m_tdata[2] !== 64'h0) begin
      errs++;
      $display("FAIL midreset_clear: got valid=%b data=%h, required 0000 0", m_tvalid, m_tdata[2]);
    end
    model_clear();
    rsti = 1'b0;
    m_tready = 4'hF;
    idle(1);
    for (int i = 0; i < 8; i++) send_byte(2'd2, 8'(8'hE0 + i), i == 7);
    comps++;
    if (m_tvalid[2] !== 1'b1 || m_tkeep[2] !== 8'hFF || m_tdata[2] !== 64'hE7E6E5E4E3E2E1E0) begin
      errs++;
      $display("FAIL midreset_new: got valid=%b keep=%h data=%h, required 1 ff e7e6e5e4e3e2e1e0",
               m_tvalid[2], m_tkeep[2], m_tdata[2]);
    end
    idle(4);
  endtask

  initial begin
    model_clear();
    for (int c = 0; c < 4; c++) begin
      rx_cnt[c] = 0;
      prev_stall[c] = 1'b0;
      prev_word[c] = '0;
    end
    test_reset();
    test_full_word();
    test_short_packets();
    test_interleave();
    test_backpressure();
    test_drain_load();
    test_mid_reset();
    for (int c = 0; c < 4; c++) begin
      comps++;
      if (exp_q[c].size() != 0) begin
        errs++;
        $display("FAIL missing ch%0d: got %0d words undelivered, required 0", c, exp_q[c].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", comps, errs);
    $finish;
  end

endmodule
